// File: rtl/aoi_pkg.sv
// aoi_pkg: shared definitions for the aoi_pipe evaluator.
//   aoi_mode_e : evaluation mode (MODE_AOI = 0, MODE_OAI = 1)
//   DEF_W      : default operand width
//   DEF_N      : default number of operand pairs
//   DEF_CNT_W  : default transaction counter width
package aoi_pkg;

  typedef enum logic {
    MODE_AOI = 1'b0,
    MODE_OAI = 1'b1
  } aoi_mode_e;

  localparam int DEF_W     = 4;
  localparam int DEF_N     = 2;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/aoi_stage.sv
// aoi_stage: one registered pipeline stage with valid/ready handshake.
// Parameters:
//   DW        : payload width
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset (clears valid and payload)
//   in_valid  : upstream payload valid
//   in_ready  : stage can take a payload this cycle
//   in_data   : upstream payload
//   out_valid : stage holds a payload
//   out_ready : downstream accepts the payload
//   out_data  : registered payload, stable while out_valid && !out_ready
module aoi_stage #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          valid_q;
  logic [DW-1:0] data_q;

  // The stage may load whenever it is empty or its content leaves this cycle.
  assign in_ready = !valid_q || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      // Only overwrite the payload with real data, so the last result
      // remains visible after the stage drains.
      if (in_valid) begin
        data_q <= in_data;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/aoi_pipe.sv
// aoi_pipe: two-stage pipelined AND-OR-INVERT / OR-AND-INVERT evaluator for
// N operand pairs of W bits, with valid/ready flow control.
// Optional feature macro: AOI_PIPE_CNT_EN (out_cnt counter; tied to 0 if
// undefined; port list identical in both builds).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : operand bundle valid
//   in_ready   : bundle can be accepted this cycle
//   in_mode    : 0 = AOI, 1 = OAI, sampled with the bundle
//   in_op      : operands; pair k = a at [(2k)*W +: W], b at [(2k+1)*W +: W]
//   out_valid  : result valid
//   out_ready  : consumer accepts result
//   term_q     : per-pair terms (AND for AOI, OR for OAI), pair k at [k*W +: W]
//   comb_q     : terms combined across pairs (OR for AOI, AND for OAI)
//   out_q      : ~comb_q (reads 0 after reset, not ~0)
//   out_mode   : mode of the presented result
//   out_cnt    : number of completed output handshakes (wrapping)
module aoi_pipe
  import aoi_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int N     = DEF_N,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [2*N*W-1:0] in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*W-1:0]   term_q,
  output logic [W-1:0]     comb_q,
  output logic [W-1:0]     out_q,
  output logic             out_mode,
  output logic [CNT_W-1:0] out_cnt
);

  localparam int S1_W = 1 + N*W;
  localparam int S2_W = 1 + N*W + 2*W;

  // Stage-1 input: per-pair terms computed straight from the operands.
  logic [N*W-1:0] term_d;

  for (genvar gi = 0; gi < N; gi++) begin : g_pair
    logic [W-1:0] a_op;
    logic [W-1:0] b_op;
    assign a_op = in_op[(2*gi)*W   +: W];
    assign b_op = in_op[(2*gi+1)*W +: W];
    assign term_d[gi*W +: W] = (in_mode == MODE_OAI) ? (a_op | b_op) : (a_op & b_op);
  end

  logic [S1_W-1:0] s1_din;
  logic [S1_W-1:0] s1_dout;
  logic            s1_valid;
  logic            s2_in_ready;

  assign s1_din = {in_mode, term_d};

  aoi_stage #(.DW(S1_W)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_din),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_dout)
  );

  logic           s1_mode;
  logic [N*W-1:0] s1_term;
  logic [W-1:0]   comb_d;

  assign s1_mode = s1_dout[S1_W-1];
  assign s1_term = s1_dout[N*W-1:0];

  // Reduction across pairs; identity element depends on the mode.
  always_comb begin
    comb_d = (s1_mode == MODE_OAI) ? {W{1'b1}} : '0;
    for (int k = 0; k < N; k++) begin
      if (s1_mode == MODE_OAI) begin
        comb_d = comb_d & s1_term[k*W +: W];
      end else begin
        comb_d = comb_d | s1_term[k*W +: W];
      end
    end
  end

  // Terms travel with the combined value so every output describes one bundle.
  logic [S2_W-1:0] s2_din;
  logic [S2_W-1:0] s2_dout;

  assign s2_din = {s1_mode, s1_term, comb_d, ~comb_d};

  aoi_stage #(.DW(S2_W)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   (s2_din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_dout)
  );

  assign out_mode = s2_dout[S2_W-1];
  assign term_q   = s2_dout[2*W +: N*W];
  assign comb_q   = s2_dout[W +: W];
  assign out_q    = s2_dout[W-1:0];

`ifdef AOI_PIPE_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Natural wrap at 2^CNT_W.
  assign cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (out_valid && out_ready) begin
      cnt_q <= cnt_d;
    end
  end

  assign out_cnt = cnt_q;
`else
  assign out_cnt = '0;
`endif

endmodule
